// File: rtl/des_key_sched.sv
// DES key-schedule generator: expands a 64-bit key into the sixteen 48-bit
// round subkeys, presenting one per valid/ready handshake. Encrypt order
// rotates C/D left (K1..K16); decrypt order rotates right (K16..K1), so the
// round engine never needs all sixteen subkeys stored at once.
module des_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Permuted choice 1: DES key bit numbers (1 = key[63]), first entry is C bit 1.
    localparam logic [56*8-1:0] PC1_TAB = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    // Permuted choice 2: bit numbers into the 56-bit {C,D} (1 = C bit 1).
    localparam logic [48*8-1:0] PC2_TAB = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    logic [0:0]  state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;

    logic [55:0] pc1_key;
    logic [55:0] cd;
    logic [7:0]  key_parity_unused;
    logic        handshake;
    logic        shift_two;

    // PC-1 is pure wiring from the key input.
    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            localparam int SRC = 64 - int'(PC1_TAB[(55 - gi) * 8 +: 8]);
            assign pc1_key[55 - gi] = key[SRC];
        end
        // Parity bits (DES bits 8,16,..,64) take no part in the schedule.
        for (gi = 0; gi < 8; gi++) begin : g_parity
            assign key_parity_unused[gi] = key[8 * gi];
        end
    endgenerate

    // PC-2 is taken combinationally from the C/D registers, so the subkey
    // is stable for as long as C/D hold during a stall.
    assign cd = {c_q, d_q};
    generate
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            localparam int SRC = 56 - int'(PC2_TAB[(47 - gi) * 8 +: 8]);
            assign subkey[47 - gi] = cd[SRC];
        end
    endgenerate

    function automatic logic [27:0] rot_l(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    assign handshake = (state_q == ST_RUN) && subkey_ready;
    // Single-bit rotations fall on the handshakes leading to K2, K9, K16 when
    // encrypting; the decrypt sequence mirrors the same three handshakes.
    assign shift_two = !((idx_q == 4'd0) || (idx_q == 4'd7) || (idx_q == 4'd14));

    // Next-state logic: load on start in IDLE, rotate on each accepted subkey.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dec_d   = decrypt;
                    idx_d   = 4'd0;
                    // C16/D16 equal C0/D0, so decrypt starts from the raw halves.
                    if (decrypt) begin
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rot_l(pc1_key[55:28], 1'b0);
                        d_d = rot_l(pc1_key[27:0], 1'b0);
                    end
                end
            end
            default: begin
                if (handshake) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        c_d   = dec_q ? rot_r(c_q, shift_two) : rot_l(c_q, shift_two);
                        d_d   = dec_q ? rot_r(d_q, shift_two) : rot_l(d_q, shift_two);
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign subkey_valid = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign round_idx    = idx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: table of schedule runs checked against
// the published subkeys of key 0x133457799BBCDFF1, plus hand-written
// sequences for start-while-busy, back-to-back start and mid-run reset.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [47:0] kexp [16];

    typedef struct {
        logic [63:0] key;
        bit          dec;
        bit          bp;
    } vec_t;

    vec_t vecs [6];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic start_sched(input logic [63:0] k, input bit dec);
        start   = 1'b1;
        key     = k;
        decrypt = dec;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs from the first valid cycle to the negedge of the done cycle.
    task automatic run_body(input bit dec, input bit bp, input bit poke);
        int hs;
        int cyc;
        logic [47:0] exp_k;
        hs  = 0;
        cyc = 0;
        while (hs < 16 && cyc < 200) begin
            subkey_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (poke && hs == 5) begin
                start   = 1'b1;
                key     = 64'hFFFF0000FFFF0000;
                decrypt = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            exp_k = dec ? kexp[15 - hs] : kexp[hs];
            chk("valid", 64'(subkey_valid), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("done_early", 64'(done), 64'd0);
            chk("round_idx", 64'(round_idx), 64'(hs));
            chk("subkey", 64'(subkey), 64'(exp_k));
            if (subkey_ready) begin
                $display("handshake %0d idx %0d subkey %h", hs, round_idx, subkey);
                hs++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b0;
        chk("handshakes", 64'(hs), 64'd16);
        if (!bp) chk("run_cycles", 64'(cyc), 64'd16);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("valid_end", 64'(subkey_valid), 64'd0);
        chk("idx_end", 64'(round_idx), 64'd0);
    endtask

    task automatic idle_after();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_valid", 64'(subkey_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kexp = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                 48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                 48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        // Keys differing from KEY_A only in parity bits share its schedule.
        vecs[0] = '{KEY_A,                 1'b0, 1'b0};
        vecs[1] = '{KEY_A,                 1'b1, 1'b0};
        vecs[2] = '{KEY_A,                 1'b0, 1'b1};
        vecs[3] = '{64'h123456789ABCDEF0, 1'b0, 1'b0};
        vecs[4] = '{64'h133557799BBDDFF1, 1'b0, 1'b0};
        vecs[5] = '{64'h123456789ABCDEF0, 1'b1, 1'b1};

        // Reset with start asserted: reset must win.
        rst          = 1'b1;
        start        = 1'b1;
        decrypt      = 1'b0;
        key          = KEY_A;
        subkey_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        for (int v = 0; v < 6; v++) begin
            $display("run %0d key %h decrypt %0d backpressure %0d", v, vecs[v].key, vecs[v].dec, vecs[v].bp);
            start_sched(vecs[v].key, vecs[v].dec);
            run_body(vecs[v].dec, vecs[v].bp, 1'b0);
            idle_after();
        end

        // start with a different key and decrypt=1 while busy is ignored.
        $display("run start-while-busy");
        start_sched(KEY_A, 1'b0);
        run_body(1'b0, 1'b0, 1'b1);
        idle_after();

        // start during the done cycle is accepted immediately.
        $display("run back-to-back");
        start_sched(KEY_A, 1'b0);
        run_body(1'b0, 1'b0, 1'b0);
        start   = 1'b1;
        key     = KEY_A;
        decrypt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_body(1'b1, 1'b0, 1'b0);
        idle_after();

        // Reset coincident with handshake 7 aborts without a done pulse.
        $display("run reset-abort");
        start_sched(KEY_A, 1'b0);
        for (int hs = 0; hs < 8; hs++) begin
            subkey_ready = 1'b1;
            if (hs == 7) rst = 1'b1;
            @(negedge clk);
            chk("abort_idx", 64'(round_idx), 64'(hs));
            chk("abort_subkey", 64'(subkey), 64'(kexp[hs]));
            $display("handshake %0d idx %0d subkey %h", hs, round_idx, subkey);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_subkey_zero", 64'(subkey), 64'd0);
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_idx_zero", 64'(round_idx), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        subkey_ready = 1'b0;
        start_sched(KEY_A, 1'b0);
        run_body(1'b0, 1'b0, 1'b0);
        idle_after();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key-schedule generator that expands a 64-bit key into the sixteen 48-bit round subkeys, one per handshake, in encrypt order (K1..K16, left rotations) or decrypt order (K16..K1, right rotations). It sits beside the round datapath that consumes the S-box substitution stages. It feeds that datapath one subkey per round, so the same round engine serves both directions without storing all sixteen subkeys.

## Interface
Parameters: none; all widths are fixed by FIPS 46-3.

- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Request a new schedule. Sampled only in IDLE.
- decrypt  in  1  0 = encrypt order, 1 = decrypt order. Sampled with start.
- key  in  64  DES key. key[63] is DES bit 1. Parity bits are ignored. Sampled with start.
- subkey  out  48  Current round subkey. subkey[47] is PC-2 output bit 1.
- subkey_valid  out  1  subkey and round_idx are valid.
- subkey_ready  in  1  Consumer accepts the subkey when subkey_valid && subkey_ready.
- round_idx  out  4  Handshake count, 0..15. Encrypt carries subkey K(round_idx+1); decrypt carries K(16-round_idx).
- busy  out  1  High from the cycle after start is accepted until done.
- done  out  1  One-cycle pulse after the 16th handshake.

## Operation
- State machine: IDLE and RUN.
- IDLE → RUN on start. In that cycle the block loads C (28 bits) and D (28 bits) from PC-1(key) and latches decrypt.
  - Encrypt: C and D are rotated left by 1 as they are loaded, giving C1/D1.
  - Decrypt: C and D load unrotated, since C16/D16 equal C0/D0.
- In RUN, subkey = PC-2(C,D), registered or combinational from the C/D registers. It must be stable while valid and not yet accepted.
- On each accepted handshake with round_idx < 15:
  - round_idx increments.
  - C and D rotate independently by the shift amount for the next subkey.
  - Encrypt left-rotation amounts, for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt right-rotation amount for handshake n (n = 1..15) equals the encrypt amount for round 17-n, i.e. 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On the handshake with round_idx = 15:
  - RUN → IDLE.
  - subkey_valid and busy deassert next cycle.
  - done pulses for exactly that next cycle.
  - round_idx returns to 0.
- start is ignored while busy. key and decrypt are not re-sampled during RUN.
- When subkey_ready is low, the block stalls indefinitely. subkey, round_idx and C/D hold.
- Rotations are modulo 28 on each half. There is no carry between C and D.

## Timing
- Reset values: subkey = 0, subkey_valid = 0, round_idx = 0, busy = 0, done = 0. C and D clear to 0 and the state is IDLE.
- rst has priority over all other inputs, including in the same cycle as start or a handshake.
- rst asserted mid-schedule aborts immediately. No done pulse is produced.
- Latency: start accepted at edge T gives subkey_valid = 1 and busy = 1 from T+1, with the first subkey presented.
- Throughput: with subkey_ready held high, one subkey per cycle.
  - Valid spans T+1..T+16.
  - done is high at T+17. busy is low at T+17.
- start may be asserted in the done cycle, since the block is already IDLE. It is accepted, and valid is high again the following cycle.
- subkey_valid never drops without a handshake, except on reset.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, ready held high:
  - First subkey 0x1B02EFFC7072 (round_idx 0).
  - 16th subkey 0xCB3D8B0E17F5 (round_idx 15).
  - done at T+17.
- Decrypt, same key: first subkey 0xCB3D8B0E17F5 and last 0x1B02EFFC7072. All 16 subkeys equal the encrypt sequence reversed.
- Backpressure: toggle ready pseudo-randomly during the encrypt run.
  - Subkey and round_idx hold while ready is low.
  - The sequence is identical to the free-running case.
  - done occurs after exactly 16 handshakes.
- start pulsed during RUN with a different key and decrypt = 1 is ignored. The current sequence completes unchanged.
- rst at handshake 7 clears all outputs to 0 next cycle with no done pulse. A following start with key 0x133457799BBCDFF1 yields 0x1B02EFFC7072 first.
- Parity invariance: key 0x123456789ABCDEF0 and the same key with every byte's LSB flipped produce identical 16-subkey sequences.
